// File: rtl/lpc_dbg_pkg.sv
// Shared LPC debug definitions: bus nibble codes and the snooper state encoding.
// Also imported by qspi_slave so both ends agree on state and nibble values.
package lpc_dbg_pkg;

    localparam logic [3:0] LAD_START  = 4'b0000;
    localparam logic [3:0] CYC_IO_WR  = 4'b0010;
    localparam logic [3:0] SYNC_READY = 4'b0000;
    localparam logic [3:0] SYNC_SHORT = 4'b0101;
    localparam logic [3:0] SYNC_LONG  = 4'b0110;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CYC    = 3'd1,
        ADDR   = 3'd2,
        DATA   = 3'd3,
        TAR    = 3'd4,
        SYNC   = 3'd5,
        COMMIT = 3'd6
    } lpc_state_t;

endpackage

// File: rtl/lpc_io_snoop.sv
// Passive LPC snooper: captures host I/O writes to a 4-byte POST port window
// and presents the last byte written to each port, with a one-clock hit strobe.
module lpc_io_snoop
    import lpc_dbg_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR    = 16'h0080,
    parameter logic [5:0]  SYNC_TIMEOUT = 6'd32
) (
    input  logic       lpc_clk_l,
    input  logic       lpc_rst_l,
    input  logic       lpc_v3p3_s0,
    input  logic       lpc_frame_l,
    input  logic [3:0] lpc_lad,
    output logic [7:0] port_80,
    output logic [7:0] port_81,
    output logic [7:0] port_82,
    output logic [7:0] port_83,
    output logic       lpc_hit,
    output logic [1:0] hit_idx
);

    lpc_state_t      state_reg, state_next;
    logic [1:0]      nib_cnt_reg, nib_cnt_next;
    logic [5:0]      wait_cnt_reg, wait_cnt_next;
    logic [15:0]     addr_reg, addr_next;
    logic [7:0]      data_reg, data_next;
    logic [3:0][7:0] port_reg, port_next;
    logic            hit_reg, hit_next;
    logic [1:0]      idx_reg, idx_next;

    always_ff @(posedge lpc_clk_l or negedge lpc_rst_l) begin
        if (!lpc_rst_l) begin
            state_reg    <= IDLE;
            nib_cnt_reg  <= 2'd0;
            wait_cnt_reg <= 6'd0;
            addr_reg     <= 16'h0000;
            data_reg     <= 8'h00;
            port_reg     <= '0;
            hit_reg      <= 1'b0;
            idx_reg      <= 2'd0;
        end else begin
            state_reg    <= state_next;
            nib_cnt_reg  <= nib_cnt_next;
            wait_cnt_reg <= wait_cnt_next;
            addr_reg     <= addr_next;
            data_reg     <= data_next;
            port_reg     <= port_next;
            hit_reg      <= hit_next;
            idx_reg      <= idx_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        nib_cnt_next  = nib_cnt_reg;
        wait_cnt_next = wait_cnt_reg;
        addr_next     = addr_reg;
        data_next     = data_reg;
        port_next     = port_reg;
        hit_next      = 1'b0;
        idx_next      = idx_reg;

        // Power loss beats LFRAME#, which in turn beats the cycle decode.
        if (!lpc_v3p3_s0) begin
            state_next = IDLE;
        end else if (!lpc_frame_l) begin
            state_next = (lpc_lad == LAD_START) ? CYC : IDLE;
        end else begin
            case (state_reg)
                IDLE: state_next = IDLE;
                CYC: begin
                    nib_cnt_next = 2'd0;
                    state_next   = (lpc_lad == CYC_IO_WR) ? ADDR : IDLE;
                end
                ADDR: begin
                    addr_next    = {addr_reg[11:0], lpc_lad};
                    nib_cnt_next = nib_cnt_reg + 2'd1;
                    if (nib_cnt_reg == 2'd3) begin
                        nib_cnt_next = 2'd0;
                        state_next   = DATA;
                    end
                end
                DATA: begin
                    // Low nibble arrives first, so shift in from the top.
                    data_next    = {lpc_lad, data_reg[7:4]};
                    nib_cnt_next = nib_cnt_reg + 2'd1;
                    if (nib_cnt_reg == 2'd1) begin
                        nib_cnt_next = 2'd0;
                        state_next   = TAR;
                    end
                end
                TAR: begin
                    nib_cnt_next = nib_cnt_reg + 2'd1;
                    if (nib_cnt_reg == 2'd1) begin
                        nib_cnt_next  = 2'd0;
                        wait_cnt_next = 6'd0;
                        state_next    = SYNC;
                    end
                end
                SYNC: begin
                    if (lpc_lad == SYNC_READY) begin
                        state_next = COMMIT;
                    end else if ((lpc_lad == SYNC_SHORT || lpc_lad == SYNC_LONG) &&
                                 wait_cnt_reg != SYNC_TIMEOUT - 6'd1) begin
                        wait_cnt_next = wait_cnt_reg + 6'd1;
                    end else begin
                        state_next = IDLE;
                    end
                end
                COMMIT: begin
                    if (addr_reg[15:2] == BASE_ADDR[15:2]) begin
                        port_next[addr_reg[1:0]] = data_reg;
                        hit_next                 = 1'b1;
                        idx_next                 = addr_reg[1:0];
                    end
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign port_80 = port_reg[0];
    assign port_81 = port_reg[1];
    assign port_82 = port_reg[2];
    assign port_83 = port_reg[3];
    assign lpc_hit = hit_reg;
    assign hit_idx = idx_reg;

endmodule
